// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control path and display top:
// FSM state encoding and the default button debounce time.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_LAP     = 2'd3
  } sw_state_e;

  localparam int DEBOUNCE_MS_DEFAULT = 20;

endpackage

// File: rtl/button_debounce.sv
// Synchronizes a raw pushbutton, accepts a new level after DEBOUNCE_MS stable
// ms ticks, and emits a one-clk press pulse one clk after each accepted rising edge.
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_tick,
  input  logic btn_raw,
  output logic press
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_MS - 1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       deb_q, deb_d;
  logic       deb_dly_q, deb_dly_d;
  logic       press_q, press_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    cnt_d     = cnt_q;
    deb_dly_d = deb_q;
    // Any sample that agrees with the accepted level restarts the stability window.
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (ms_tick) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
    press_d = deb_q & ~deb_dly_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      press_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      press_q   <= press_d;
      cnt_q     <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounced start/stop and lap/reset buttons drive
// an IDLE/RUNNING/PAUSED/LAP FSM producing count enable, clear pulse and display freeze.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ms_tick,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  output logic       run_en,
  output logic       clr,
  output logic       freeze,
  output logic [1:0] state
);

  logic      ss_press, lr_press;
  sw_state_e state_q, state_d;
  logic      clr_q, clr_d;

  button_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_ss (
    .clk     (clk),
    .rst     (rst),
    .ms_tick (ms_tick),
    .btn_raw (btn_start_stop),
    .press   (ss_press)
  );

  button_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_lr (
    .clk     (clk),
    .rst     (rst),
    .ms_tick (ms_tick),
    .btn_raw (btn_lap_reset),
    .press   (lr_press)
  );

  // start/stop takes priority; a coincident lap/reset press is dropped.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ss_press) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (ss_press)      state_d = ST_PAUSED;
        else if (lr_press) state_d = ST_LAP;
      end
      ST_LAP: begin
        if (ss_press)      state_d = ST_PAUSED;
        else if (lr_press) state_d = ST_RUNNING;
      end
      ST_PAUSED: begin
        if (ss_press) begin
          state_d = ST_RUNNING;
        end else if (lr_press) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  assign run_en = (state_q == ST_RUNNING) || (state_q == ST_LAP);
  assign freeze = (state_q == ST_LAP);
  assign clr    = clr_q;
  assign state  = state_q;

endmodule
